pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline (PC, FD, DX, XM, MW registers).
- Turns the following events into per-stage stall and flush controls each cycle:
  - multi-cycle instruction/data memory handshakes
  - load-use hazards
  - control redirects
  - halt
- Tracks outstanding memory waits and fetches squashed by a redirect across cycles.
- Keeps a saturating stall-cycle counter and a data-memory timeout flag.

Parameters:
- CNT_W, 16, width of stall_cycles counter.
- DMEM_TIMEOUT, 0, max consecutive data-memory wait cycles before dmem_err; 0 disables the check.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_done  in  1  fetch memory returns a valid instruction this cycle.
- dmem_req  in  1  XM stage issues a load/store this cycle.
- dmem_done  in  1  data memory completes the XM access this cycle.
- load_use  in  1  DX holds a load whose writeReg matches an FD source register.
- redirect  in  1  taken branch/jump resolved in X; PC is loaded with the new target.
- mw_halt  in  1  HALT instruction present in MW (valid, not flushed).
- pc_stall  out  1  hold PC.
- fd_stall  out  1  hold FD register.
- fd_flush  out  1  load NOP/flush bit into FD.
- dx_stall  out  1  hold DX register.
- dx_flush  out  1  load bubble into DX.
- xm_stall  out  1  hold XM register.
- mw_stall  out  1  hold MW register (drives the MW register's stall input).
- halted  out  1  sticky; processor stopped.
- dmem_err  out  1  sticky; data-memory wait exceeded DMEM_TIMEOUT.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_stall=1.

Behaviour:
- **Reset** (rst=1 at clk edge):
  - state=RUN, squash_pend=0, dwait_cnt=0, stall_cycles=0, halted=0, dmem_err=0.
  - While rst is high, all stall/flush outputs are 0.
- **Output timing:** stall/flush outputs are combinational (Mealy) from current state and inputs, so they take effect at the same clk edge as the triggering event. Registered state updates at the edge.
- **States:** RUN, DWAIT, HALT.
- **Priority when several events coincide in RUN:** halt > dmem wait > redirect > load_use > fetch wait.
- **HALT (highest priority)** — entered from any state when mw_halt=1:
  - Outputs in the entry cycle and every cycle after: all five stalls=1, flushes=0.
  - halted=1 from the next cycle. HALT is exited only by rst.
- **Data-memory wait** — RUN with dmem_req=1 and dmem_done=0:
  - Outputs: pc/fd/dx/xm/mw stalls all 1, flushes 0.
  - Next state DWAIT.
- **DWAIT:**
  - Holds all stalls=1 while dmem_done=0.
  - On dmem_done=1, stalls drop in that same cycle and next state is RUN.
  - dmem_req=1 with dmem_done=1 in the same RUN cycle causes no stall.
- **Redirect:**
  - fd_flush=1, dx_flush=1, pc_stall=0, other stalls 0.
  - If imem_done=0 in that cycle, set squash_pend=1: a fetch of the wrong path is in flight.
- **Load-use:**
  - pc_stall=1, fd_stall=1, dx_flush=1; xm_stall=0, mw_stall=0.
- **Fetch wait** — imem_done=0:
  - pc_stall=1, fd_flush=1; back end (DX/XM/MW) advances.
- **squash_pend=1:**
  - Every cycle: pc_stall=1, fd_flush=1 (the wrong-path word is discarded).
  - Cleared on the first cycle with imem_done=1; in that cycle fd_flush=1 and pc_stall=0.
  - A second redirect while squash_pend=1 keeps squash_pend set.
- **stall_cycles:**
  - Increments on every cycle with pc_stall=1, including DWAIT and HALT.
  - Saturates at 2^CNT_W-1; no wrap.
- **dwait_cnt:**
  - Counts consecutive DWAIT cycles; cleared on leaving DWAIT.
  - If DMEM_TIMEOUT>0 and dwait_cnt reaches DMEM_TIMEOUT, dmem_err=1 (sticky). Stalling continues regardless.
- **Reset mid-operation** (DWAIT, squash_pend, or HALT): returns to RUN with all registers cleared at the next edge.

Decomposition:
- Package pipe_ctrl_pkg:
  - state encodings RUN=2'b00, DWAIT=2'b01, HALT=2'b10
  - priority documentation constants
  - default CNT_W
- Sub-module sat_counter (parameter W; inputs clk, rst, inc; output cnt, saturating):
  - used for stall_cycles and dwait_cnt, the latter with a clear input.

Test Plan:
- **Reset release, imem_done=1, no events** → all stall/flush outputs 0 for 10 cycles; stall_cycles=0.
- **dmem_req=1, dmem_done=0 for 3 cycles, then dmem_done=1:**
  - all five stalls=1 for exactly 3 cycles and 0 in the done cycle;
  - stall_cycles=3;
  - with DMEM_TIMEOUT=2, dmem_err rises after the 2nd wait cycle.
- **load_use=1 for 1 cycle** → pc_stall=1, fd_stall=1, dx_flush=1, xm_stall=0, mw_stall=0 in that cycle only.
- **redirect=1 with imem_done=0, then imem_done low for 2 more cycles, then 1:**
  - redirect cycle: fd_flush=1, dx_flush=1;
  - next 2 cycles: pc_stall=1, fd_flush=1;
  - done cycle: fd_flush=1, pc_stall=0;
  - then normal operation.
- **redirect=1, load_use=1 and dmem_req=1/dmem_done=0 in the same cycle** → dmem wait wins (all stalls=1, no flushes); after dmem_done, redirect is reapplied by the stalled X stage.
- **mw_halt=1 during squash_pend:**
  - all stalls=1 in that cycle; halted=1 from the next cycle onward;
  - stall_cycles increments each cycle;
  - rst returns halted=0, state RUN.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer: FSM states,
// hazard classes in priority order, and the per-stage control bundle.
package pipe_ctrl_pkg;

    localparam int unsigned DEFAULT_CNT_W = 16;
    localparam int unsigned DWAIT_CNT_W   = 16;

    localparam logic [1:0] RUN   = 2'b00;
    localparam logic [1:0] DWAIT = 2'b01;
    localparam logic [1:0] HALT  = 2'b10;

    // Hazard classes, enumerated from lowest to highest priority.
    typedef enum logic [2:0] {
        HZ_NONE     = 3'd0,
        HZ_FETCH    = 3'd1,
        HZ_LOAD_USE = 3'd2,
        HZ_REDIRECT = 3'd3,
        HZ_DWAIT    = 3'd4,
        HZ_HALT     = 3'd5
    } hazard_e;

    typedef struct packed {
        logic pc_stall;
        logic fd_stall;
        logic fd_flush;
        logic dx_stall;
        logic dx_flush;
        logic xm_stall;
        logic mw_stall;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_IDLE = '0;

    // Whole pipeline frozen in place: every register holds, nothing flushed.
    function automatic stage_ctrl_t freeze_all();
        stage_ctrl_t c;
        c          = CTRL_IDLE;
        c.pc_stall = 1'b1;
        c.fd_stall = 1'b1;
        c.dx_stall = 1'b1;
        c.xm_stall = 1'b1;
        c.mw_stall = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: resolves memory waits,
// load-use, redirects and halt into per-stage controls each cycle.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W        = DEFAULT_CNT_W,
    parameter int unsigned DMEM_TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_done,
    input  logic             dmem_req,
    input  logic             dmem_done,
    input  logic             load_use,
    input  logic             redirect,
    input  logic             mw_halt,
    output logic             pc_stall,
    output logic             fd_stall,
    output logic             fd_flush,
    output logic             dx_stall,
    output logic             dx_flush,
    output logic             xm_stall,
    output logic             mw_stall,
    output logic             halted,
    output logic             dmem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic                   squash_pend;
    logic                   squash_nxt;
    logic                   dmem_wait_c;
    logic                   timeout_c;
    hazard_e                hz;
    stage_ctrl_t            ctrl;
    logic [DWAIT_CNT_W-1:0] dwait_cnt;

    // Classify the dominant hazard this cycle.
    always_comb begin
        hz          = HZ_NONE;
        dmem_wait_c = (state == DWAIT) ? !dmem_done
                                       : (dmem_req && !dmem_done);
        if (rst) begin
            hz = HZ_NONE;
        end else if ((state == HALT) || mw_halt) begin
            hz = HZ_HALT;
        end else if (dmem_wait_c) begin
            hz = HZ_DWAIT;
        end else if (redirect) begin
            hz = HZ_REDIRECT;
        end else if (load_use) begin
            hz = HZ_LOAD_USE;
        end else if (squash_pend || !imem_done) begin
            hz = HZ_FETCH;
        end
    end

    // Next state and Mealy stage controls.
    always_comb begin
        ctrl       = CTRL_IDLE;
        state_nxt  = state;
        squash_nxt = squash_pend;
        case (hz)
            HZ_HALT: begin
                ctrl      = freeze_all();
                state_nxt = HALT;
            end
            HZ_DWAIT: begin
                ctrl      = freeze_all();
                state_nxt = DWAIT;
            end
            HZ_REDIRECT: begin
                ctrl.fd_flush = 1'b1;
                ctrl.dx_flush = 1'b1;
                state_nxt     = RUN;
                // Wrong-path fetch still in flight must be discarded on return.
                squash_nxt    = !imem_done;
            end
            HZ_LOAD_USE: begin
                ctrl.pc_stall = 1'b1;
                ctrl.fd_stall = 1'b1;
                ctrl.dx_flush = 1'b1;
                state_nxt     = RUN;
                if (imem_done) squash_nxt = 1'b0;
            end
            HZ_FETCH: begin
                ctrl.pc_stall = !imem_done;
                ctrl.fd_flush = 1'b1;
                state_nxt     = RUN;
                if (imem_done) squash_nxt = 1'b0;
            end
            default: begin
                state_nxt = RUN;
                if (imem_done) squash_nxt = 1'b0;
            end
        endcase
    end

    assign pc_stall = ctrl.pc_stall;
    assign fd_stall = ctrl.fd_stall;
    assign fd_flush = ctrl.fd_flush;
    assign dx_stall = ctrl.dx_stall;
    assign dx_flush = ctrl.dx_flush;
    assign xm_stall = ctrl.xm_stall;
    assign mw_stall = ctrl.mw_stall;

    // Error fires on the wait cycle that brings the consecutive count to the limit.
    assign timeout_c = (DMEM_TIMEOUT != 0) && (hz == HZ_DWAIT) &&
                       ((32'(dwait_cnt) + 32'd1) >= DMEM_TIMEOUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            squash_pend <= 1'b0;
            halted      <= 1'b0;
            dmem_err    <= 1'b0;
        end else begin
            state       <= state_nxt;
            squash_pend <= squash_nxt;
            halted      <= (state_nxt == HALT);
            if (timeout_c) dmem_err <= 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (ctrl.pc_stall),
        .cnt (stall_cycles)
    );

    sat_counter #(.W(DWAIT_CNT_W)) u_dwait_cnt (
        .clk (clk),
        .rst (rst),
        .clr (hz != HZ_DWAIT),
        .inc (hz == HZ_DWAIT),
        .cnt (dwait_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; stage controls packed as
// {pc_stall, fd_stall, fd_flush, dx_stall, dx_flush, xm_stall, mw_stall}.
module tb_pipe_hazard_ctrl;

    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_ALL   = 7'b1101011;
    localparam logic [6:0] C_LU    = 7'b1100100;
    localparam logic [6:0] C_REDIR = 7'b0010100;
    localparam logic [6:0] C_FWAIT = 7'b1010000;
    localparam logic [6:0] C_SQEND = 7'b0010000;

    logic       clk = 1'b0;
    logic       rst, imem_done, dmem_req, dmem_done, load_use, redirect, mw_halt;
    logic       pc_stall, fd_stall, fd_flush, dx_stall, dx_flush, xm_stall, mw_stall;
    logic       halted, dmem_err;
    logic [3:0] stall_cycles;
    logic [6:0] ctl;
    int         vec = 0;
    int         err = 0;

    always #5 clk = ~clk;

    assign ctl = {pc_stall, fd_stall, fd_flush, dx_stall, dx_flush, xm_stall, mw_stall};

    pipe_hazard_ctrl #(.CNT_W(4), .DMEM_TIMEOUT(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_done    (imem_done),
        .dmem_req     (dmem_req),
        .dmem_done    (dmem_done),
        .load_use     (load_use),
        .redirect     (redirect),
        .mw_halt      (mw_halt),
        .pc_stall     (pc_stall),
        .fd_stall     (fd_stall),
        .fd_flush     (fd_flush),
        .dx_stall     (dx_stall),
        .dx_flush     (dx_flush),
        .xm_stall     (xm_stall),
        .mw_stall     (mw_stall),
        .halted       (halted),
        .dmem_err     (dmem_err),
        .stall_cycles (stall_cycles)
    );

    task automatic idle_inputs();
        imem_done = 1'b1;
        dmem_req  = 1'b0;
        dmem_done = 1'b0;
        load_use  = 1'b0;
        redirect  = 1'b0;
        mw_halt   = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_done = 1'b0; dmem_req = 1'b1; dmem_done = 1'b0;
        load_use = 1'b1; redirect = 1'b1; mw_halt = 1'b1;
        @(negedge clk);
        vec++;
        if (ctl !== C_NONE) begin
            err++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_NONE);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        vec++;
        if ({halted, dmem_err, stall_cycles} !== 6'b0) begin
            err++; $display("FAIL reset_regs got halted=%b err=%b cnt=%0d exp 0/0/0",
                            halted, dmem_err, stall_cycles);
        end
        next_cycle();
    endtask

    task automatic test_idle();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vec++;
            if (ctl !== C_NONE) begin
                err++; $display("FAIL idle_ctl cyc=%0d got=%b exp=%b", i, ctl, C_NONE);
            end
            next_cycle();
        end
        @(negedge clk);
        vec++;
        if (stall_cycles !== 4'd0) begin
            err++; $display("FAIL idle_cnt got=%0d exp=0", stall_cycles);
        end
        next_cycle();
    endtask

    task automatic test_dmem_wait();
        apply_reset();
        dmem_req = 1'b1; dmem_done = 1'b1;
        @(negedge clk);
        vec++;
        if (ctl !== C_NONE) begin
            err++; $display("FAIL dmem_same_cycle got=%b exp=%b", ctl, C_NONE);
        end
        next_cycle();
        dmem_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vec++;
            if (ctl !== C_ALL) begin
                err++; $display("FAIL dmem_wait_ctl cyc=%0d got=%b exp=%b", i, ctl, C_ALL);
            end
            vec++;
            if (dmem_err !== (i == 2)) begin
                err++; $display("FAIL dmem_err cyc=%0d got=%b exp=%b", i, dmem_err, (i == 2));
            end
            next_cycle();
        end
        dmem_done = 1'b1;
        @(negedge clk);
        vec++;
        if (ctl !== C_NONE) begin
            err++; $display("FAIL dmem_done_ctl got=%b exp=%b", ctl, C_NONE);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        vec++;
        if ({ctl, dmem_err, stall_cycles} !== {C_NONE, 1'b1, 4'd3}) begin
            err++; $display("FAIL dmem_after got ctl=%b err=%b cnt=%0d exp ctl=%b err=1 cnt=3",
                            ctl, dmem_err, stall_cycles, C_NONE);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        apply_reset();
        load_use = 1'b1;
        @(negedge clk);
        vec++;
        if (ctl !== C_LU) begin
            err++; $display("FAIL load_use_ctl got=%b exp=%b", ctl, C_LU);
        end
        next_cycle();
        load_use = 1'b0;
        @(negedge clk);
        vec++;
        if ({ctl, stall_cycles} !== {C_NONE, 4'd1}) begin
            err++; $display("FAIL load_use_after got ctl=%b cnt=%0d exp ctl=%b cnt=1",
                            ctl, stall_cycles, C_NONE);
        end
        next_cycle();
    endtask

    task automatic test_redirect_squash();
        apply_reset();
        redirect = 1'b1; imem_done = 1'b0;
        @(negedge clk);
        vec++;
        if (ctl !== C_REDIR) begin
            err++; $display("FAIL redirect_ctl got=%b exp=%b", ctl, C_REDIR);
        end
        next_cycle();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vec++;
            if (ctl !== C_FWAIT) begin
                err++; $display("FAIL squash_wait cyc=%0d got=%b exp=%b", i, ctl, C_FWAIT);
            end
            next_cycle();
        end
        imem_done = 1'b1;
        @(negedge clk);
        vec++;
        if (ctl !== C_SQEND) begin
            err++; $display("FAIL squash_end got=%b exp=%b", ctl, C_SQEND);
        end
        next_cycle();
        @(negedge clk);
        vec++;
        if ({ctl, stall_cycles} !== {C_NONE, 4'd2}) begin
            err++; $display("FAIL squash_after got ctl=%b cnt=%0d exp ctl=%b cnt=2",
                            ctl, stall_cycles, C_NONE);
        end
        next_cycle();
    endtask

    task automatic test_coincide();
        apply_reset();
        redirect = 1'b1; load_use = 1'b1; dmem_req = 1'b1; dmem_done = 1'b0;
        @(negedge clk);
        vec++;
        if (ctl !== C_ALL) begin
            err++; $display("FAIL coincide_ctl got=%b exp=%b", ctl, C_ALL);
        end
        next_cycle();
        dmem_done = 1'b1;
        @(negedge clk);
        vec++;
        if (ctl !== C_REDIR) begin
            err++; $display("FAIL coincide_replay got=%b exp=%b", ctl, C_REDIR);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        vec++;
        if ({ctl, stall_cycles} !== {C_NONE, 4'd1}) begin
            err++; $display("FAIL coincide_after got ctl=%b cnt=%0d exp ctl=%b cnt=1",
                            ctl, stall_cycles, C_NONE);
        end
        next_cycle();
    endtask

    task automatic test_halt();
        apply_reset();
        redirect = 1'b1; imem_done = 1'b0;
        next_cycle();
        redirect = 1'b0; mw_halt = 1'b1;
        @(negedge clk);
        vec++;
        if ({ctl, halted} !== {C_ALL, 1'b0}) begin
            err++; $display("FAIL halt_entry got ctl=%b halted=%b exp ctl=%b halted=0",
                            ctl, halted, C_ALL);
        end
        next_cycle();
        mw_halt = 1'b0; imem_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vec++;
            if ({ctl, halted, stall_cycles} !== {C_ALL, 1'b1, 4'(i + 1)}) begin
                err++; $display("FAIL halt_hold cyc=%0d got ctl=%b halted=%b cnt=%0d exp ctl=%b halted=1 cnt=%0d",
                                i, ctl, halted, stall_cycles, C_ALL, i + 1);
            end
            next_cycle();
        end
        rst = 1'b1;
        @(negedge clk);
        vec++;
        if (ctl !== C_NONE) begin
            err++; $display("FAIL halt_rst_ctl got=%b exp=%b", ctl, C_NONE);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        vec++;
        if ({ctl, halted, stall_cycles} !== {C_NONE, 1'b0, 4'd0}) begin
            err++; $display("FAIL halt_after_rst got ctl=%b halted=%b cnt=%0d exp ctl=%b halted=0 cnt=0",
                            ctl, halted, stall_cycles, C_NONE);
        end
        next_cycle();
    endtask

    task automatic test_saturation();
        apply_reset();
        imem_done = 1'b0;
        @(negedge clk);
        vec++;
        if (ctl !== C_FWAIT) begin
            err++; $display("FAIL fetch_wait_ctl got=%b exp=%b", ctl, C_FWAIT);
        end
        for (int i = 0; i < 15; i++) next_cycle();
        @(negedge clk);
        vec++;
        if (stall_cycles !== 4'd15) begin
            err++; $display("FAIL sat_reach got=%0d exp=15", stall_cycles);
        end
        for (int i = 0; i < 5; i++) next_cycle();
        @(negedge clk);
        vec++;
        if (stall_cycles !== 4'd15) begin
            err++; $display("FAIL sat_hold got=%0d exp=15", stall_cycles);
        end
        next_cycle();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #1;
        test_reset();
        test_idle();
        test_dmem_wait();
        test_load_use();
        test_redirect_squash();
        test_coincide();
        test_halt();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
